// File: rtl/sonic_tx_status_rr_arbiter.sv
// Round-robin merge of NUM_IN single-beat TX status streams into one
// registered Avalon-ST status stream, tagged with the winning channel.
// The arbiter is work-conserving. The output stage holds its beat under
// backpressure. A 16-bit counter tracks completed output transfers.
module sonic_tx_status_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 40,
  parameter int ERR_W  = 7,
  parameter int CH_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IN-1:0]          in_valid,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  input  logic [NUM_IN*ERR_W-1:0]    in_error,
  output logic [NUM_IN-1:0]          in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [ERR_W-1:0]           out_error,
  output logic [CH_W-1:0]            out_channel,
  input  logic                       out_ready,
  output logic [15:0]                xfer_count
);

  // The pointer starts on the last source, so source 0 is scanned first
  localparam logic [CH_W-1:0] LastGrantInit = CH_W'(NUM_IN - 1);

  logic              r_outValid;
  logic [DATA_W-1:0] r_outData;
  logic [ERR_W-1:0]  r_outError;
  logic [CH_W-1:0]   r_outChannel;
  logic [CH_W-1:0]   r_lastGrant;
  logic [15:0]       r_xferCount;

  logic              w_loadEn;
  logic              w_anyGrant;
  logic [NUM_IN-1:0] w_grant;
  logic [CH_W-1:0]   w_winner;
  logic [DATA_W-1:0] w_winData;
  logic [ERR_W-1:0]  w_winError;

  // The output register can take a new beat when it is empty or being drained
  assign w_loadEn = ~r_outValid | out_ready;

  // Scan sources from the one after the last winner, wrapping; first valid wins
  always_comb begin
    w_grant    = '0;
    w_winner   = '0;
    w_anyGrant = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!w_anyGrant && in_valid[i] &&
            (i == ((int'(r_lastGrant) + k) % NUM_IN))) begin
          w_anyGrant = 1'b1;
          w_grant[i] = 1'b1;
          w_winner   = CH_W'(i);
        end
      end
    end
  end

  // Select the winner's payload using the one-hot grant
  always_comb begin
    w_winData  = '0;
    w_winError = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_grant[i]) begin
        w_winData  = in_data[i*DATA_W +: DATA_W];
        w_winError = in_error[i*ERR_W +: ERR_W];
      end
    end
  end

  // Only the granted source sees ready, and only when the output can load
  assign in_ready = w_grant & {NUM_IN{w_loadEn}};

  // The output stage captures the winner, or empties when nothing is requesting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outValid   <= 1'b0;
      r_outData    <= '0;
      r_outError   <= '0;
      r_outChannel <= '0;
      r_lastGrant  <= LastGrantInit;
    end else if (w_loadEn) begin
      r_outValid <= w_anyGrant;
      if (w_anyGrant) begin
        r_outData    <= w_winData;
        r_outError   <= w_winError;
        r_outChannel <= w_winner;
        r_lastGrant  <= w_winner;
      end
    end
  end

  // Count beats leaving the output stage; wraps naturally at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xferCount <= '0;
    end else if (r_outValid && out_ready) begin
      r_xferCount <= r_xferCount + 16'd1;
    end
  end

  assign out_valid   = r_outValid;
  assign out_data    = r_outData;
  assign out_error   = r_outError;
  assign out_channel = r_outChannel;
  assign xfer_count  = r_xferCount;

endmodule

// File: tb/tb_sonic_tx_status_rr_arbiter.sv
// Bench for the round-robin TX status arbiter: directed scenarios, then
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_sonic_tx_status_rr_arbiter;

  localparam int NumIn = 4;
  localparam int DataW = 40;
  localparam int ErrW  = 7;
  localparam int ChW   = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [NumIn-1:0]        in_valid = '0;
  logic [NumIn*DataW-1:0]  in_data = '0;
  logic [NumIn*ErrW-1:0]   in_error = '0;
  logic [NumIn-1:0]        in_ready;
  logic                    out_valid;
  logic [DataW-1:0]        out_data;
  logic [ErrW-1:0]         out_error;
  logic [ChW-1:0]          out_channel;
  logic                    out_ready = 1'b0;
  logic [15:0]             xfer_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit               mValid;
  logic [DataW-1:0] mData;
  logic [ErrW-1:0]  mErr;
  int               mCh;
  int               mLast;
  logic [15:0]      mCount;
  logic [NumIn-1:0] lastExpReady;

  sonic_tx_status_rr_arbiter #(
    .NUM_IN(NumIn), .DATA_W(DataW), .ERR_W(ErrW), .CH_W(ChW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_error(out_error),
    .out_channel(out_channel), .out_ready(out_ready),
    .xfer_count(xfer_count)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NumIn-1:0] valid, input logic ready);
    in_valid  = valid;
    out_ready = ready;
  endtask

  task automatic setPayload(input int src, input logic [DataW-1:0] d,
                            input logic [ErrW-1:0] e);
    in_data[src*DataW +: DataW] = d;
    in_error[src*ErrW +: ErrW]  = e;
  endtask

  task automatic modelReset();
    mValid = 1'b0;
    mData  = '0;
    mErr   = '0;
    mCh    = 0;
    mLast  = NumIn - 1;
    mCount = '0;
  endtask

  // First requesting source after the previous winner, or -1 when idle
  function automatic int pickWinner();
    for (int k = 1; k <= NumIn; k++) begin
      int j;
      j = (mLast + k) % NumIn;
      if (in_valid[j]) return j;
    end
    return -1;
  endfunction

  // One clock: check ready before the edge, update the model, check outputs after
  task automatic runCycle(input bit doCheck);
    int w;
    bit le;
    logic [NumIn-1:0] expReady;
    #1;
    le = !mValid || out_ready;
    w = pickWinner();
    expReady = '0;
    if (w >= 0 && le) expReady[w] = 1'b1;
    lastExpReady = expReady;
    if (doCheck) checkOutput("in_ready", 64'(in_ready), 64'(expReady));
    @(posedge clk);
    if (mValid && out_ready) mCount = mCount + 16'd1;
    if (le) begin
      if (w >= 0) begin
        mValid = 1'b1;
        mData  = in_data[w*DataW +: DataW];
        mErr   = in_error[w*ErrW +: ErrW];
        mCh    = w;
        mLast  = w;
      end else begin
        mValid = 1'b0;
      end
    end
    #1;
    if (doCheck) begin
      checkOutput("out_valid", 64'(out_valid), 64'(mValid));
      checkOutput("out_data", 64'(out_data), 64'(mData));
      checkOutput("out_error", 64'(out_error), 64'(mErr));
      checkOutput("out_channel", 64'(out_channel), 64'(mCh));
      checkOutput("xfer_count", 64'(xfer_count), 64'(mCount));
    end
  endtask

  // Assert reset between edges and confirm it takes effect without a clock
  task automatic doReset();
    reset = 1'b1;
    modelReset();
    #2;
    checkOutput("rst_valid_async", 64'(out_valid), 64'd0);
    checkOutput("rst_xfer_async", 64'(xfer_count), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_data", 64'(out_data), 64'd0);
    checkOutput("rst_error", 64'(out_error), 64'd0);
    checkOutput("rst_channel", 64'(out_channel), 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] r64;
    bit [NumIn-1:0] pend;
    int guard;

    modelReset();
    lastExpReady = '0;
    pend = '0;
    #1;
    doReset();

    // Single beat from source 0
    setPayload(0, 40'h12_3456_789A, 7'h05);
    applyStimulus(4'b0001, 1'b1);
    #1;
    checkOutput("single_ready", 64'(in_ready), 64'h1);
    runCycle(1);
    checkOutput("single_valid", 64'(out_valid), 64'd1);
    checkOutput("single_data", 64'(out_data), 64'h12_3456_789A);
    checkOutput("single_err", 64'(out_error), 64'h05);
    checkOutput("single_ch", 64'(out_channel), 64'd0);
    applyStimulus(4'b0000, 1'b1);
    runCycle(1);
    checkOutput("single_xfer", 64'(xfer_count), 64'd1);

    // All four continuously valid: strict rotation
    doReset();
    for (int s = 0; s < NumIn; s++)
      setPayload(s, 40'hA0_0000_0000 + 40'(s * 16'h1111), 7'(s + 1));
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 8; k++) begin
      runCycle(1);
      checkOutput("rotate_ch", 64'(out_channel), 64'(k % NumIn));
    end
    applyStimulus(4'b0000, 1'b1);
    runCycle(1);
    checkOutput("rotate_xfer", 64'(xfer_count), 64'd8);

    // Backpressure holding source 2's beat
    setPayload(2, 40'h22_2222_2222, 7'h22);
    applyStimulus(4'b0100, 1'b0);
    runCycle(1);
    setPayload(0, 40'h00_0000_0AAA, 7'h0A);
    setPayload(3, 40'h33_3333_3333, 7'h33);
    applyStimulus(4'b1001, 1'b0);
    for (int k = 0; k < 5; k++) begin
      runCycle(1);
      checkOutput("bp_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_data", 64'(out_data), 64'h22_2222_2222);
      checkOutput("bp_ch", 64'(out_channel), 64'd2);
    end
    applyStimulus(4'b1001, 1'b1);
    #1;
    checkOutput("bp_release_ready", 64'(in_ready), 64'b1000);
    runCycle(1);
    checkOutput("bp_next_ch", 64'(out_channel), 64'd3);
    runCycle(1);
    checkOutput("bp_after_ch", 64'(out_channel), 64'd0);

    // Sparse: only source 1, then sources 1 and 2
    applyStimulus(4'b0010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      setPayload(1, 40'h11_0000_0000 + 40'(k), 7'h11);
      runCycle(1);
      checkOutput("sparse_ch", 64'(out_channel), 64'd1);
    end
    applyStimulus(4'b0110, 1'b1);
    #1;
    checkOutput("sparse_pair_ready", 64'(in_ready), 64'b0100);
    runCycle(1);
    checkOutput("sparse_pair_ch", 64'(out_channel), 64'd2);

    // Reset mid-stream while stalled
    applyStimulus(4'b0010, 1'b0);
    runCycle(1);
    checkOutput("midrst_pre_valid", 64'(out_valid), 64'd1);
    doReset();
    applyStimulus(4'b1111, 1'b1);
    #1;
    checkOutput("midrst_ready", 64'(in_ready), 64'b0001);
    runCycle(1);
    checkOutput("midrst_first_ch", 64'(out_channel), 64'd0);

    // Randomized traffic with sources honouring the hold rule
    doReset();
    applyStimulus(4'b0000, 1'b0);
    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j < NumIn; j++) begin
        if (!pend[j] && ($urandom_range(0, 99) < 55)) begin
          pend[j] = 1'b1;
          r64 = {$urandom, $urandom};
          setPayload(j, r64[39:0], r64[46:40]);
        end
      end
      applyStimulus(pend, ($urandom_range(0, 99) < 70));
      runCycle(1);
      pend = pend & ~lastExpReady;
    end

    // Counter wrap
    doReset();
    applyStimulus(4'b1111, 1'b1);
    guard = 0;
    while (mCount != 16'hFFFF && guard < 70000) begin
      runCycle(0);
      guard++;
    end
    checkOutput("wrap_budget", 64'(guard < 70000), 64'd1);
    checkOutput("wrap_pre", 64'(xfer_count), 64'hFFFF);
    runCycle(1);
    checkOutput("wrap_zero", 64'(xfer_count), 64'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
